// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// Imported by the loader RTL and its testbench.
package prog_loader_pkg;

   localparam int ADDR_WIDTH = 10;
   localparam int DATA_WIDTH = 16;
   localparam int MAX_WORDS  = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      COUNT_HI,
      COUNT_LO,
      DATA_HI,
      DATA_LO,
      CHECK,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> 16-bit instruction memory writes.
// Holds the core in reset until a complete, checksum-valid image is loaded.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int AddrWidth = ADDR_WIDTH,
   parameter int DataWidth = DATA_WIDTH
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iValid,
   input  logic [7:0]           iByte,
   output logic                 oReady,
   output logic                 oWrEnable,
   output logic [AddrWidth-1:0] oAddress,
   output logic [DataWidth-1:0] oInstr,
   output logic                 oCoreReset,
   output logic                 oDone,
   output logic                 oError
);

   localparam logic [16:0] MaxN = 17'(1) << AddrWidth;

   state_t               state;
   state_t               next;
   logic                 accept;
   logic [7:0]           cnt_hi;
   logic [7:0]           hi_byte;
   logic [7:0]           csum;
   logic [15:0]          count;
   logic                 count_ok;
   logic                 last_word;
   logic [AddrWidth:0]   nwords;
   logic [AddrWidth:0]   wcnt;
   logic [AddrWidth-1:0] waddr;

   assign accept    = iValid && oReady;
   assign count     = {cnt_hi, iByte};
   assign count_ok  = (count != 16'd0) && ({1'b0, count} <= MaxN);
   assign last_word = (wcnt + (AddrWidth+1)'(1)) == nwords;

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state <= COUNT_HI;
      else       state <= next;
   end

   // Next-state decode; only an accepted byte moves the FSM
   always_comb begin
      next = state;
      if (accept) begin
         unique case (state)
            COUNT_HI: next = COUNT_LO;
            COUNT_LO: next = count_ok ? DATA_HI : ERROR;
            DATA_HI:  next = DATA_LO;
            DATA_LO:  next = last_word ? CHECK : DATA_HI;
            CHECK:    next = (iByte == csum) ? DONE : ERROR;
            default:  next = state;
         endcase
      end
   end

   // Datapath, write port and status outputs, all registered
   always_ff @(posedge Clock) begin
      if (Reset) begin
         oReady     <= 1'b1;
         oWrEnable  <= 1'b0;
         oAddress   <= '0;
         oInstr     <= '0;
         oCoreReset <= 1'b1;
         oDone      <= 1'b0;
         oError     <= 1'b0;
         cnt_hi     <= '0;
         hi_byte    <= '0;
         csum       <= '0;
         nwords     <= '0;
         wcnt       <= '0;
         waddr      <= '0;
      end else begin
         oWrEnable  <= 1'b0;
         oReady     <= (next != DONE) && (next != ERROR);
         oDone      <= (next == DONE);
         oError     <= (next == ERROR);
         oCoreReset <= (next != DONE);
         if (accept) begin
            csum <= csum + iByte;
            unique case (state)
               COUNT_HI: cnt_hi <= iByte;
               COUNT_LO: nwords <= count[AddrWidth:0];
               DATA_HI:  hi_byte <= iByte;
               DATA_LO: begin
                  oWrEnable <= 1'b1;
                  oAddress  <= waddr;
                  oInstr    <= DataWidth'({hi_byte, iByte});
                  waddr     <= waddr + AddrWidth'(1);
                  wcnt      <= wcnt + (AddrWidth+1)'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader.
// Expected writes and final status come from a stream-level model.
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       iValid = 1'b0;
   logic [7:0] iByte = 8'h00;
   logic       oReady;
   logic       oWrEnable;
   logic [9:0] oAddress;
   logic [15:0] oInstr;
   logic       oCoreReset;
   logic       oDone;
   logic       oError;

   int n_chk = 0;
   int n_fail = 0;

   logic [25:0] exp_q[$];
   logic        acc_q = 1'b0;
   logic        we_q = 1'b0;
   logic [7:0]  s[$];

   prog_loader dut (
      .Clock(Clock),
      .Reset(Reset),
      .iValid(iValid),
      .iByte(iByte),
      .oReady(oReady),
      .oWrEnable(oWrEnable),
      .oAddress(oAddress),
      .oInstr(oInstr),
      .oCoreReset(oCoreReset),
      .oDone(oDone),
      .oError(oError)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Remember whether the previous edge accepted a byte
   always @(posedge Clock) acc_q <= iValid && oReady && !Reset;

   // Scoreboard every write strobe against the model's queue
   always @(negedge Clock) begin
      logic [25:0] e;
      if (oWrEnable) begin
         chk("wr_after_accept", 32'(acc_q), 32'd1);
         chk("wr_one_cycle", 32'(we_q), 32'd0);
         if (exp_q.size() == 0) begin
            chk("wr_extra", {6'd0, oAddress, oInstr}, 32'hFFFFFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(oAddress), 32'(e[25:16]));
            chk("wr_data", 32'(oInstr), 32'(e[15:0]));
         end
      end
      we_q = oWrEnable;
   end

   task automatic do_reset();
      Reset = 1'b1;
      iValid = 1'b0;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      chk("rst_ready", 32'(oReady), 32'd1);
      chk("rst_we", 32'(oWrEnable), 32'd0);
      chk("rst_addr", 32'(oAddress), 32'd0);
      chk("rst_instr", 32'(oInstr), 32'd0);
      chk("rst_core", 32'(oCoreReset), 32'd1);
      chk("rst_done", 32'(oDone), 32'd0);
      chk("rst_error", 32'(oError), 32'd0);
   endtask

   task automatic check_final(input int res);
      chk("fin_done", 32'(oDone), 32'(res == 1));
      chk("fin_error", 32'(oError), 32'(res == 2));
      chk("fin_core", 32'(oCoreReset), 32'(res != 1));
      chk("fin_ready", 32'(oReady), 32'd0);
   endtask

   // Build a well-formed image of n words; optionally corrupt the checksum
   task automatic mk(input int n, input bit bad, input bit addr_words,
                     output logic [7:0] q[$]);
      int sum;
      logic [15:0] w;
      q.delete();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         w = addr_words ? 16'(i) : 16'($urandom);
         q.push_back(w[15:8]);
         q.push_back(w[7:0]);
      end
      sum = 0;
      foreach (q[k]) sum += int'(q[k]);
      q.push_back(8'(sum % 256 + (bad ? 1 : 0)));
   endtask

   // Feed a stream (optionally only its first `limit_in` bytes)
   task automatic run_stream(input logic [7:0] q[$], input bit rnd,
                             input int limit_in);
      int n, limit, decide, res, sum, i, budget;
      logic rdy;
      limit = (limit_in < 0) ? q.size() : limit_in;
      n = int'(q[0]) * 256 + int'(q[1]);
      if (n == 0 || n > MAX_WORDS) begin
         decide = 1;
         res = 2;
      end else begin
         for (int w = 0; w < n; w++)
            if (3 + 2 * w < limit)
               exp_q.push_back({10'(w), q[2+2*w], q[3+2*w]});
         decide = 2 + 2 * n;
         sum = 0;
         for (int k = 0; k < decide; k++) sum += int'(q[k]);
         res = ((sum % 256) == int'(q[decide])) ? 1 : 2;
      end
      i = 0;
      budget = 0;
      while (i < limit && budget < 20000) begin
         budget++;
         iValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         iByte = iValid ? q[i] : 8'($urandom);
         rdy = oReady;
         @(posedge Clock);
         #1;
         if (iValid && rdy) begin
            if (i == decide) check_final(res);
            else if (i == 0 || i == limit - 1) begin
               chk("busy_ready", 32'(oReady), 32'd1);
               chk("busy_core", 32'(oCoreReset), 32'd1);
            end
            i++;
         end
      end
      iValid = 1'b0;
      if (budget >= 20000) chk("timeout", 32'd1, 32'd0);
      repeat (3) @(posedge Clock);
      #1;
      chk("writes_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      if (limit_in < 0) check_final(res);
   endtask

   initial begin
      do_reset();

      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
      run_stream(s, 1'b0, -1);
      do_reset();

      s[6] = 8'hC1;
      run_stream(s, 1'b0, -1);
      do_reset();

      s = '{8'h00, 8'h00};
      run_stream(s, 1'b0, -1);
      do_reset();

      s = '{8'h04, 8'h01};
      run_stream(s, 1'b0, -1);
      do_reset();

      s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
      run_stream(s, 1'b1, -1);
      do_reset();

      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
      run_stream(s, 1'b0, 5);
      do_reset();
      run_stream(s, 1'b0, -1);
      do_reset();

      repeat (8) begin
         mk($urandom_range(1, 6), ($urandom % 3) == 0, 1'b0, s);
         run_stream(s, 1'b1, -1);
         do_reset();
      end

      mk(MAX_WORDS, 1'b0, 1'b1, s);
      run_stream(s, 1'b0, -1);
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
